// File: rtl/fpms_32.sv
// ============================================================================
// Module   : fpms_32
// Purpose  : Sequential IEEE-754 single-precision multiplier (shift-add
//            mantissa loop, normalise, optional round-to-nearest-even when
//            FPMS_ROUND_EN is defined; truncation otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpms_32 #(
  parameter int N    = 24,
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        unf
);

  localparam int P_W = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [4:0]          r_cnt;
  logic [P_W-1:0]      r_acc;
  logic [N-1:0]        r_mcand;
  logic [N-1:0]        r_mplr;
  logic                r_sign;
  logic                r_zero;
  logic signed [9:0]   r_exp;
  logic [31:0]         r_res;
  logic                r_res_ovf;
  logic                r_res_unf;

  // Partial-product add into the upper accumulator half, carry kept for the shift.
  logic [N:0]          w_sum;
  assign w_sum = {1'b0, r_acc[P_W-1:N]} + (r_mplr[0] ? {1'b0, r_mcand} : '0);

  logic                w_hi;
  logic [N-2:0]        w_frac;
  logic [N-2:0]        w_frac_f;
  logic signed [9:0]   w_exp_n;
  logic signed [9:0]   w_exp_f;

  assign w_hi    = r_acc[P_W-1];
  assign w_frac  = w_hi ? r_acc[P_W-2:N] : r_acc[P_W-3:N-1];
  assign w_exp_n = r_exp + {9'd0, w_hi};

`ifdef FPMS_ROUND_EN
  logic                w_guard;
  logic                w_sticky;
  logic                w_inc;
  logic                w_carry;
  logic [N-2:0]        w_frac_r;

  assign w_guard  = w_hi ? r_acc[N-1] : r_acc[N-2];
  assign w_sticky = w_hi ? |r_acc[N-2:0] : |r_acc[N-3:0];
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign {w_carry, w_frac_r} = {1'b0, w_frac} + {{(N-1){1'b0}}, w_inc};
  // All-ones significand rounding up becomes 1.0 at the next exponent.
  assign w_frac_f = w_carry ? '0 : w_frac_r;
  assign w_exp_f  = w_exp_n + {9'd0, w_carry};
`else
  assign w_frac_f = w_frac;
  assign w_exp_f  = w_exp_n;
`endif

  logic [31:0]         w_res;
  logic                w_ovf;
  logic                w_unf;

  always_comb begin
    w_res = {r_sign, 8'd0, {(N-1){1'b0}}};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_zero) begin
      w_res = {r_sign, 31'd0};
    end else if (w_exp_f >= 10'sd255) begin
      w_res = {r_sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      w_res = {r_sign, 31'd0};
      w_unf = 1'b1;
    end else begin
      w_res = {r_sign, w_exp_f[7:0], w_frac_f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_exp     <= '0;
      r_res     <= '0;
      r_res_ovf <= 1'b0;
      r_res_unf <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= {1'b1, a[22:0]};
            r_mplr  <= {1'b1, b[22:0]};
            r_acc   <= '0;
            r_cnt   <= 5'd0;
            r_sign  <= a[31] ^ b[31];
            r_zero  <= (a[30:23] == 8'd0) | (b[30:23] == 8'd0);
            r_exp   <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
            busy    <= 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc  <= {w_sum, r_acc[N-1:1]};
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'(N - 1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_res     <= w_res;
          r_res_ovf <= w_ovf;
          r_res_unf <= w_unf;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          product <= r_res;
          ovf     <= r_res_ovf;
          unf     <= r_res_unf;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpms_32.sv
// ============================================================================
// Module   : tb_fpms_32
// Purpose  : Self-checking bench for fpms_32 against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpms_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] product;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int failures = 0;

  fpms_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, then normalise/round from the value.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] p, output logic o, output logic u);
    int ea;
    int eb;
    int e;
    int sh;
    logic s;
    longint unsigned mx;
    longint unsigned my;
    longint unsigned full;
    longint unsigned m;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    o  = 1'b0;
    u  = 1'b0;
    p  = {s, 31'd0};
    if (ea == 0 || eb == 0) return;
    mx   = 64'(x[22:0]) + 64'd8388608;
    my   = 64'(y[22:0]) + 64'd8388608;
    full = mx * my;
    sh   = (full >= (64'd1 << 47)) ? 24 : 23;
    e    = ea + eb - 127 + (sh - 23);
    m    = full >> sh;
`ifdef FPMS_ROUND_EN
    begin
      longint unsigned rem;
      longint unsigned half;
      rem  = full - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e = e + 1;
      end
    end
`endif
    if (e >= 255) begin
      p = {s, 8'hFF, 23'd0};
      o = 1'b1;
    end else if (e <= 0) begin
      u = 1'b1;
    end else begin
      p = {s, 8'(e), m[22:0]};
    end
  endfunction

  // Issue one operation; operands are scrambled right after acceptance.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] p, output logic o, output logic u,
                       output int lat, output logic busy_acc);
    logic [31:0] r;
    @(negedge clk);
    a = oa;
    b = ob;
    start = 1'b1;
    @(posedge clk);
    #1;
    busy_acc = busy;
    start = 1'b0;
    r = $urandom();
    a = r;
    r = $urandom();
    b = r;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    p = product;
    o = ovf;
    u = unf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({product, busy, done, ovf, unf} !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: got product=%h busy=%b done=%b ovf=%b unf=%b expected all zero",
               product, busy, done, ovf, unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vp [7];
    logic [1:0]  vf [7];
    logic [31:0] p;
    logic o;
    logic u;
    logic ba;
    int lat;
    va[0] = 32'h40000000; vb[0] = 32'h40400000; vp[0] = 32'h40C00000; vf[0] = 2'b00;
    va[1] = 32'h3FC00000; vb[1] = 32'h3FC00000; vp[1] = 32'h40100000; vf[1] = 2'b00;
    va[2] = 32'hC0000000; vb[2] = 32'h3F000000; vp[2] = 32'hBF800000; vf[2] = 2'b00;
    va[3] = 32'h00000000; vb[3] = 32'h40A00000; vp[3] = 32'h00000000; vf[3] = 2'b00;
    va[4] = 32'h7F000000; vb[4] = 32'h7F000000; vp[4] = 32'h7F800000; vf[4] = 2'b10;
    va[5] = 32'h00800000; vb[5] = 32'h00800000; vp[5] = 32'h00000000; vf[5] = 2'b01;
    va[6] = 32'h3F800001; vb[6] = 32'h3FC00000; vf[6] = 2'b00;
`ifdef FPMS_ROUND_EN
    vp[6] = 32'h3FC00002;
`else
    vp[6] = 32'h3FC00001;
`endif
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], p, o, u, lat, ba);
      checks++;
      if (p !== vp[i] || {o, u} !== vf[i]) begin
        failures++;
        $display("FAIL directed_%0d: got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                 i, p, o, u, vp[i], vf[i][1], vf[i][0]);
      end
      checks++;
      if (lat !== 26 || ba !== 1'b1) begin
        failures++;
        $display("FAIL latency_%0d: got lat=%0d busy=%b expected lat=26 busy=1", i, lat, ba);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse_%0d: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] oa;
    logic [31:0] ob;
    logic [31:0] r;
    logic [31:0] p;
    logic [31:0] ep;
    logic o;
    logic u;
    logic eo;
    logic eu;
    logic ba;
    int lat;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom();
      oa = {r[31], 8'($urandom_range(0, 254)), r[22:0]};
      r  = $urandom();
      ob = {r[31], 8'($urandom_range(0, 254)), r[22:0]};
      ref_mul(oa, ob, ep, eo, eu);
      do_op(oa, ob, p, o, u, lat, ba);
      checks++;
      if (p !== ep || o !== eo || u !== eu || lat !== 26) begin
        failures++;
        $display("FAIL random_%0d: %h*%h got %h ovf=%b unf=%b lat=%0d expected %h ovf=%b unf=%b lat=26",
                 i, oa, ob, p, o, u, lat, ep, eo, eu);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 32'h40000000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 4) begin
        start = 1'b1;
        a = 32'h3FC00000;
        b = 32'h41200000;
      end
      if (lat == 5) start = 1'b0;
      if (done) break;
    end
    checks++;
    if (product !== 32'h40C00000 || lat !== 26) begin
      failures++;
      $display("FAIL ignore_start: got %h lat=%0d expected 40c00000 lat=26", product, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    logic o;
    logic u;
    logic ba;
    int lat;
    int seen;
    @(negedge clk);
    a = 32'hC0000000;
    b = 32'h3F000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({product, busy, done, ovf, unf} !== 36'd0) begin
      failures++;
      $display("FAIL reset_mid: got product=%h busy=%b done=%b expected zero", product, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_abandon: got %0d active cycles expected 0", seen);
    end
    do_op(32'h3FC00000, 32'h3FC00000, p, o, u, lat, ba);
    checks++;
    if (p !== 32'h40100000 || lat !== 26) begin
      failures++;
      $display("FAIL after_reset: got %h lat=%0d expected 40100000 lat=26", p, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
